// File: rtl/decode.sv
// ============================================================================
// Module      : decode
// Description : LC3 decode stage. Waits MEM_LATENCY cycles for instruction
//               memory, latches the IR and splits it into fields. The optional
//               reserved-opcode trap is enabled with DECODE_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_start,
  input  logic [15:0] mem_data_in,
  output logic        busy,
  output logic        execute_start,
  output logic [15:0] ir_out,
  output logic [3:0]  opCode_out,
  output logic [2:0]  dr_out,
  output logic [2:0]  sr1_out,
  output logic [2:0]  sr2_out,
  output logic        imm_flag_out,
  output logic [15:0] imm5_out,
  output logic [8:0]  offset_out,
  output logic [10:0] offset11_out,
  output logic [2:0]  br_nzp_out
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic        illegal_out
`endif
);

  localparam logic [3:0] c_cnt_init = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_ir;
  logic        w_accept;
  logic        w_capture;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (decode_start) begin
          w_state_next = S_WAIT;
          w_accept     = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_ISSUE;
          w_capture    = 1'b1;
        end
      end
      S_ISSUE: begin
        // A start during ISSUE is accepted directly, skipping IDLE.
        if (decode_start) begin
          w_state_next = S_WAIT;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cnt <= c_cnt_init;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_capture) begin
        r_ir <= mem_data_in;
      end
    end
  end

  assign busy = (r_state == S_WAIT);

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic w_illegal;
  assign w_illegal     = (r_ir[15:12] == 4'b1101);
  assign illegal_out   = w_illegal;
  assign execute_start = (r_state == S_ISSUE) && !w_illegal;
`else
  assign execute_start = (r_state == S_ISSUE);
`endif

  // Field outputs are pure wiring from the IR; only imm5 is sign-extended.
  assign ir_out       = r_ir;
  assign opCode_out   = r_ir[15:12];
  assign dr_out       = r_ir[11:9];
  assign sr1_out      = r_ir[8:6];
  assign sr2_out      = r_ir[2:0];
  assign imm_flag_out = r_ir[5];
  assign imm5_out     = {{11{r_ir[4]}}, r_ir[4:0]};
  assign offset_out   = r_ir[8:0];
  assign offset11_out = r_ir[10:0];
  assign br_nzp_out   = r_ir[11:9];

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// ============================================================================
// Module      : tb_decode
// Description : Self-checking bench for decode: directed scenarios plus a
//               randomized run against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode;

  localparam int L = 2;

  logic        clk;
  logic        rst_n;
  logic        decode_start;
  logic [15:0] mem_data_in;
  logic        busy;
  logic        execute_start;
  logic [15:0] ir_out;
  logic [3:0]  opCode_out;
  logic [2:0]  dr_out;
  logic [2:0]  sr1_out;
  logic [2:0]  sr2_out;
  logic        imm_flag_out;
  logic [15:0] imm5_out;
  logic [8:0]  offset_out;
  logic [10:0] offset11_out;
  logic [2:0]  br_nzp_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal_out;
`endif

  int errors = 0;
  int checks = 0;

  decode #(.MEM_LATENCY(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .decode_start (decode_start),
    .mem_data_in  (mem_data_in),
    .busy         (busy),
    .execute_start(execute_start),
    .ir_out       (ir_out),
    .opCode_out   (opCode_out),
    .dr_out       (dr_out),
    .sr1_out      (sr1_out),
    .sr2_out      (sr2_out),
    .imm_flag_out (imm_flag_out),
    .imm5_out     (imm5_out),
    .offset_out   (offset_out),
    .offset11_out (offset11_out),
    .br_nzp_out   (br_nzp_out)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_out  (illegal_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses decode_start with instr on the bus; returns cycles from the start
  // edge to the first execute_start (or -1 if none within the budget).
  task automatic issue(input logic [15:0] instr, output int lat);
    decode_start = 1'b1;
    mem_data_in  = instr;
    tick();
    decode_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (execute_start) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    decode_start = 1'b0;
    mem_data_in = 16'hFFFF;
    repeat (5) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || execute_start !== 1'b0 || ir_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset: busy=%b exec=%b ir=%h, required 0 0 0000", busy, execute_start, ir_out);
    end
    checks++;
    if ({opCode_out, dr_out, sr1_out, sr2_out, imm_flag_out, imm5_out, offset_out, offset11_out, br_nzp_out} !== '0) begin
      errors++;
      $display("FAIL reset_fields: opcode=%h imm5=%h off=%h, required all zero", opCode_out, imm5_out, offset_out);
    end
  endtask

  task automatic test_alu_reg();
    int lat;
    issue(16'h1283, lat);
    checks++;
    if (lat !== L) begin
      errors++;
      $display("FAIL alu_latency: got %0d required %0d", lat, L);
    end
    checks++;
    if (opCode_out !== 4'h1 || dr_out !== 3'd1 || sr1_out !== 3'd2 || imm_flag_out !== 1'b0 || sr2_out !== 3'd3) begin
      errors++;
      $display("FAIL alu_fields: op=%h dr=%0d sr1=%0d imm=%b sr2=%0d, required 1 1 2 0 3",
               opCode_out, dr_out, sr1_out, imm_flag_out, sr2_out);
    end
    tick();
    checks++;
    if (execute_start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse_width: exec=%b busy=%b, required 0 0", execute_start, busy);
    end
  endtask

  task automatic test_imm();
    int lat;
    issue(16'h12BF, lat);
    checks++;
    if (lat !== L || imm_flag_out !== 1'b1 || imm5_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL imm: lat=%0d imm_flag=%b imm5=%h, required %0d 1 ffff", lat, imm_flag_out, imm5_out, L);
    end
    tick();
  endtask

  task automatic test_lea_br();
    int lat;
    issue(16'hE7FE, lat);
    checks++;
    if (lat !== L || opCode_out !== 4'hE || dr_out !== 3'd3 || offset_out !== 9'h1FE) begin
      errors++;
      $display("FAIL lea: lat=%0d op=%h dr=%0d off=%h, required %0d e 3 1fe", lat, opCode_out, dr_out, offset_out, L);
    end
    tick();
    issue(16'h0C05, lat);
    checks++;
    if (lat !== L || br_nzp_out !== 3'b110 || offset_out !== 9'h005 || offset11_out !== 11'h405) begin
      errors++;
      $display("FAIL br: lat=%0d nzp=%b off=%h off11=%h, required %0d 110 005 405",
               lat, br_nzp_out, offset_out, offset11_out, L);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(16'h5020, lat);
    checks++;
    if (lat !== L) begin
      errors++;
      $display("FAIL b2b_first: latency %0d required %0d", lat, L);
    end
    // Still in the ISSUE cycle: request the next instruction immediately.
    decode_start = 1'b1;
    mem_data_in  = 16'h3A41;
    tick();
    decode_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || execute_start !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: busy=%b exec=%b, required 1 0", busy, execute_start);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || ir_out !== 16'h5020) begin
      errors++;
      $display("FAIL b2b_wait: busy=%b ir=%h, required 1 5020", busy, ir_out);
    end
    tick();
    checks++;
    if (execute_start !== 1'b1 || ir_out !== 16'h3A41) begin
      errors++;
      $display("FAIL b2b_second: exec=%b ir=%h, required 1 3a41", execute_start, ir_out);
    end
    tick();
  endtask

  task automatic test_wait_ignore();
    int pulses = 0;
    decode_start = 1'b1;
    mem_data_in  = 16'h6042;
    tick();
    decode_start = 1'b1;
    tick();
    decode_start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (execute_start) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 1 || ir_out !== 16'h6042) begin
      errors++;
      $display("FAIL wait_ignore: pulses=%0d ir=%h, required 1 6042", pulses, ir_out);
    end
  endtask

  task automatic test_reset_mid_wait();
    int pulses = 0;
    int lat;
    decode_start = 1'b1;
    mem_data_in  = 16'h2FFF;
    tick();
    decode_start = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || execute_start !== 1'b0 || ir_out !== 16'h0000) begin
      errors++;
      $display("FAIL rst_mid_wait: busy=%b exec=%b ir=%h, required 0 0 0000", busy, execute_start, ir_out);
    end
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      if (execute_start) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 0 || ir_out !== 16'h0000) begin
      errors++;
      $display("FAIL rst_abort: pulses=%0d ir=%h, required 0 0000", pulses, ir_out);
    end
    issue(16'h9283, lat);
    checks++;
    if (lat !== L || ir_out !== 16'h9283) begin
      errors++;
      $display("FAIL rst_recover: lat=%0d ir=%h, required %0d 9283", lat, ir_out, L);
    end
    tick();
  endtask

  task automatic test_reserved();
    int lat;
    issue(16'hD000, lat);
`ifdef DECODE_ILLEGAL_TRAP_EN
    checks++;
    if (lat !== -1 || illegal_out !== 1'b1 || opCode_out !== 4'hD) begin
      errors++;
      $display("FAIL reserved_trap: lat=%0d illegal=%b op=%h, required -1 1 d", lat, illegal_out, opCode_out);
    end
`else
    checks++;
    if (lat !== L || opCode_out !== 4'hD) begin
      errors++;
      $display("FAIL reserved_plain: lat=%0d op=%h, required %0d d", lat, opCode_out, L);
    end
`endif
    tick();
  endtask

  // Reference: a request seen while no fetch is outstanding schedules a
  // capture L edges later; execute_start follows the capture edge.
  task automatic test_random();
    int          cap_edge;
    logic [15:0] ir_m;
    logic        exec_m;
    logic        ds;
    logic [15:0] md;
    int          v;
    logic [15:0] imm_m;
    rst_n = 1'b0;
    decode_start = 1'b0;
    tick();
    rst_n = 1'b1;
    cap_edge = -1;
    ir_m = 16'h0000;
    for (int k = 0; k < 400; k++) begin
      ds = ($urandom_range(0, 2) == 0);
      md = 16'($urandom);
      if ($urandom_range(0, 7) == 0) md = (md & 16'h0FFF) | 16'hD000;
      decode_start = ds;
      mem_data_in  = md;
      tick();
      exec_m = 1'b0;
      if (cap_edge == k) begin
        ir_m = md;
        cap_edge = -1;
        exec_m = 1'b1;
      end else if (cap_edge == -1 && ds) begin
        cap_edge = k + L;
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      if ((ir_m >> 12) == 16'd13) exec_m = 1'b0;
      checks++;
      if (illegal_out !== ((ir_m >> 12) == 16'd13)) begin
        errors++;
        $display("FAIL rand_illegal cycle %0d: got %b ir=%h", k, illegal_out, ir_m);
      end
`endif
      v = int'(ir_m & 16'd31);
      if (v >= 16) v = v - 32;
      imm_m = 16'(v);
      checks++;
      if (busy !== (cap_edge != -1) || execute_start !== exec_m || ir_out !== ir_m) begin
        errors++;
        $display("FAIL rand_ctrl cycle %0d: busy=%b exec=%b ir=%h, required %b %b %h",
                 k, busy, execute_start, ir_out, cap_edge != -1, exec_m, ir_m);
      end
      checks++;
      if (opCode_out !== 4'(ir_m >> 12) || dr_out !== 3'((ir_m >> 9) & 7) ||
          sr1_out !== 3'((ir_m >> 6) & 7) || sr2_out !== 3'(ir_m & 7) ||
          imm_flag_out !== 1'((ir_m >> 5) & 1) || imm5_out !== imm_m ||
          offset_out !== 9'(ir_m % 512) || offset11_out !== 11'(ir_m % 2048) ||
          br_nzp_out !== 3'((ir_m >> 9) & 7)) begin
        errors++;
        $display("FAIL rand_fields cycle %0d: ir=%h op=%h imm5=%h off=%h off11=%h, required imm5=%h",
                 k, ir_m, opCode_out, imm5_out, offset_out, offset11_out, imm_m);
      end
    end
    decode_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    decode_start = 1'b0;
    mem_data_in = 16'h0000;
    test_reset();
    test_alu_reg();
    test_imm();
    test_lea_br();
    test_back_to_back();
    test_wait_ignore();
    test_reset_mid_wait();
    test_reserved();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
